alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 1, ALU cycles from operand load to valid alu_result (legal 1..15).
REQ-002 SHALL have ports (clock and reset first):
 clk  in  1  sole clock, rising edge
 clr  in  1  asynchronous, active-low reset
 req_valid  in  1  operation request valid
 req_ready  out  1  sequencer accepts request
 req_op  in  5  opcode
 req_a  in  16  operand A
 req_b  in  16  operand B
 alu_rst  out  1  ALU reset
 alu_noop  out  1  ALU no-operation
 alu_cmd  out  5  ALU command
 alu_ld  out  1  operand register load strobe
 alu_a  out  16  operand A to ALU register
 alu_b  out  16  operand B to ALU register
 alu_result  in  32  ALU result
 alu_ovf  in  1  ALU overflow
 rsp_valid  out  1  response valid
 rsp_ready  in  1  response consumed
 rsp_data  out  32  captured result
 rsp_ovf  out  1  captured overflow
 rsp_err  out  1  illegal opcode or divide-by-zero
 op_count  out  16  completed responses
 busy  out  1  state not IDLE

Function
REQ-003 SHALL implement states INIT, IDLE, ISSUE, WAIT, RESP.
REQ-004 INIT: alu_rst=1, alu_noop=1; next cycle -> IDLE unconditionally.
REQ-005 IDLE: req_ready=1; req_valid&req_ready at edge latches op/a/b; legal non-error op -> ISSUE; illegal op or DIV with req_b=0 -> RESP directly, ALU never issued.
REQ-006 Opcodes: ADD 0, SUB 1, MULT 2, DIV 3, SLL 4, SRL 5, AND 6, OR 7, XOR 8, NOT 9, NAND 10, NOR 11; 12..31 illegal.
REQ-007 ISSUE: one cycle, alu_ld=1, alu_noop=0, alu_cmd/alu_a/alu_b = latched values; -> WAIT.
REQ-008 WAIT: exactly LAT cycles, alu_noop=0, alu_cmd held; 4-bit down-counter loaded with LAT-1 on ISSUE; at counter=0 edge capture alu_result/alu_ovf -> RESP.
REQ-009 Latency: accept at edge E; rsp_valid high from edge E+2+LAT.
REQ-010 RESP: rsp_valid=1; rsp_data/rsp_ovf/rsp_err stable until rsp_valid&rsp_ready edge -> IDLE.
REQ-011 Error responses: illegal op -> rsp_data=0, rsp_err=1, rsp_ovf=0; DIV by zero -> rsp_data=32'hFFFF_FFFF, rsp_err=1, rsp_ovf=0.
REQ-012 op_count increments on each rsp handshake, errors included; wraps 16'hFFFF -> 0.
REQ-013 Outside ISSUE/WAIT: alu_noop=1, alu_ld=0; alu_cmd/alu_a/alu_b hold last value.
REQ-014 req_ready=0 in every non-IDLE state; request presented during RESP handshake cycle accepted earliest next cycle.
REQ-015 rsp_ready asserted with rsp_valid low SHALL have no effect.
REQ-016 busy = (state != IDLE).

Reset
REQ-017 clr low SHALL asynchronously force INIT; deassertion synchronous to clk.
REQ-018 Reset values: alu_rst=1, alu_noop=1, alu_ld=0, alu_cmd=0, alu_a=0, alu_b=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0, op_count=0, busy=1.
REQ-019 clr mid-WAIT or mid-RESP SHALL abandon operation; no response, op_count cleared.

Structure
REQ-020 Shared package SHALL hold opcode constants, state enum, OP_LAST=11, DIV_ZERO_RESULT constant.
REQ-021 Single module; the WAIT counter stays inline, no sub-module.

Verification
REQ-022 Reset release, LAT=1: INIT one cycle (alu_rst=1), then IDLE req_ready=1, op_count=0.
REQ-023 ADD a=16'hFFFF b=16'h0001, rsp_ready=1, model ALU -> rsp_data=32'h0001_0000, rsp_ovf=1, rsp_err=0, rsp_valid at E+3.
REQ-024 DIV a=100 b=0 -> rsp_valid at E+1, rsp_data=32'hFFFF_FFFF, rsp_err=1, alu_ld never high.
REQ-025 req_op=5'd20 -> rsp_data=0, rsp_err=1; op_count=1 after handshake.
REQ-026 LAT=4, MULT 300x300, rsp_ready low 5 cycles -> rsp_data=32'd90000 held stable, req_ready=0 throughout, IDLE after handshake.
REQ-027 clr pulsed low during WAIT -> immediate INIT values, no rsp_valid, op_count=0.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - opcodes, state encoding and error constants for the ALU command sequencer
package alu_cmd_sequencer_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MULT = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_NAND = 5'd10;
    localparam logic [4:0] OP_NOR  = 5'd11;

    // Highest legal opcode; everything above it is rejected without touching the ALU.
    localparam logic [4:0] OP_LAST = OP_NOR;

    localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // A request that must be answered directly with an error response.
    function automatic logic op_is_error(input logic [4:0] op, input logic [15:0] b);
        return (op > OP_LAST) || ((op == OP_DIV) && (b == 16'd0));
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - sequences one request at a time through a fixed-latency ALU
//
// Ports:
//   clk, clr                 clock (rising edge) and asynchronous active-low reset
//   req_valid/ready/op/a/b   request handshake, opcode and 16-bit operands
//   alu_rst, alu_noop        ALU reset and no-operation controls
//   alu_cmd, alu_ld          ALU command and operand-load strobe
//   alu_a, alu_b             operands presented to the ALU operand registers
//   alu_result, alu_ovf      ALU result and overflow, valid LAT cycles after load
//   rsp_valid/ready          response handshake
//   rsp_data/ovf/err         captured result, overflow and error flag
//   op_count                 number of completed response handshakes (wraps)
//   busy                     high whenever the sequencer is not idle
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        alu_rst,
    output logic        alu_noop,
    output logic [4:0]  alu_cmd,
    output logic        alu_ld,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic [15:0] op_count,
    output logic        busy
);

    state_t     state;
    logic [3:0] wait_cnt;

    // Every output is registered and updated on the transition into the state
    // it belongs to, so outputs always reflect the current state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_INIT;
            wait_cnt  <= 4'd0;
            alu_rst   <= 1'b1;
            alu_noop  <= 1'b1;
            alu_ld    <= 1'b0;
            alu_cmd   <= 5'd0;
            alu_a     <= 16'd0;
            alu_b     <= 16'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
            op_count  <= 16'd0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    alu_rst   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (op_is_error(req_op, req_b)) begin
                            // Rejected requests skip the ALU entirely; the ALU
                            // command and operand outputs keep their old values.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_ovf   <= 1'b0;
                            rsp_data  <= (req_op > OP_LAST) ? 32'd0 : DIV_ZERO_RESULT;
                            state     <= ST_RESP;
                        end else begin
                            alu_cmd  <= req_op;
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_ld   <= 1'b1;
                            alu_noop <= 1'b0;
                            state    <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    alu_ld   <= 1'b0;
                    wait_cnt <= 4'(LAT - 1);
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_data  <= alu_result;
                        rsp_ovf   <= alu_ovf;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        alu_noop  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer at LAT=1 and LAT=4
module tb_alu_cmd_sequencer;

    logic clk;
    logic clr;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [4:0]  req_op    [2];
    logic [15:0] req_a     [2];
    logic [15:0] req_b     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_ovf   [2];
    logic        rsp_err   [2];
    logic [15:0] op_count  [2];
    logic        busy      [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: 16-bit operands, zero-extended 32-bit result, {ovf, result}.
    function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic        o;
        r = 32'd0;
        o = 1'b0;
        case (c)
            5'd0:  begin r = {16'd0, a} + {16'd0, b}; o = r[16]; end
            5'd1:  begin r = {16'd0, a} - {16'd0, b}; o = (a < b); end
            5'd2:  r = {16'd0, a} * {16'd0, b};
            5'd3:  r = (b == 16'd0) ? 32'd0 : {16'd0, a / b};
            5'd4:  r = {16'd0, a << b[3:0]};
            5'd5:  r = {16'd0, a >> b[3:0]};
            5'd6:  r = {16'd0, a & b};
            5'd7:  r = {16'd0, a | b};
            5'd8:  r = {16'd0, a ^ b};
            5'd9:  r = {16'd0, ~a};
            5'd10: r = {16'd0, ~(a & b)};
            5'd11: r = {16'd0, ~(a | b)};
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    // Expected response {err, ovf, data} for a request.
    function automatic logic [33:0] model_rsp(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op > 5'd11)
            return {1'b1, 1'b0, 32'h0000_0000};
        if (op == 5'd3 && b == 16'd0)
            return {1'b1, 1'b0, 32'hFFFF_FFFF};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 1 : 4;

        logic        alu_rst, alu_noop, alu_ld, alu_ovf;
        logic [4:0]  alu_cmd;
        logic [15:0] alu_a, alu_b;
        logic [31:0] alu_result;

        alu_cmd_sequencer #(.LAT(L)) dut (
            .clk        (clk),
            .clr        (clr),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_op     (req_op[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .alu_rst    (alu_rst),
            .alu_noop   (alu_noop),
            .alu_cmd    (alu_cmd),
            .alu_ld     (alu_ld),
            .alu_a      (alu_a),
            .alu_b      (alu_b),
            .alu_result (alu_result),
            .alu_ovf    (alu_ovf),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .rsp_ovf    (rsp_ovf[g]),
            .rsp_err    (rsp_err[g]),
            .op_count   (op_count[g]),
            .busy       (busy[g])
        );

        // ALU model: operands load on alu_ld; result shows garbage until L cycles
        // after the load cycle, so an early capture is visible.
        logic [4:0]  la_cmd = 5'd0;
        logic [15:0] la_a = 16'd0, la_b = 16'd0;
        int          acnt = 0;
        logic        aload = 1'b0;
        logic [32:0] alu_out;

        always @(posedge clk) begin
            if (alu_ld) begin
                la_cmd <= alu_cmd;
                la_a   <= alu_a;
                la_b   <= alu_b;
                acnt   <= L - 1;
                aload  <= 1'b1;
            end else if (acnt > 0) begin
                acnt <= acnt - 1;
            end
        end

        assign alu_out    = alu_fn(la_cmd, la_a, la_b);
        assign alu_result = (aload && acnt == 0) ? alu_out[31:0] : 32'hDEAD_BEEF;
        assign alu_ovf    = (aload && acnt == 0) ? alu_out[32] : 1'b1;

        // Transaction-level model: one outstanding request at most.
        logic        pend = 1'b0, m_init = 1'b1;
        logic        exp_err = 1'b0, exp_ovf = 1'b0;
        logic [31:0] exp_data = 32'd0;
        logic [4:0]  exp_cmd = 5'd0;
        logic [15:0] exp_a = 16'd0, exp_b = 16'd0, mcount = 16'd0;
        logic        exp_ready;

        assign exp_ready = clr && !m_init && !pend;

        always @(posedge clk or negedge clr) begin
            if (!clr) begin
                pend   <= 1'b0;
                m_init <= 1'b1;
                mcount <= 16'd0;
            end else begin
                m_init <= 1'b0;
                if (req_valid[g] && exp_ready) begin
                    {exp_err, exp_ovf, exp_data} <= model_rsp(req_op[g], req_a[g], req_b[g]);
                    exp_cmd <= req_op[g];
                    exp_a   <= req_a[g];
                    exp_b   <= req_b[g];
                    pend    <= 1'b1;
                end else if (pend && rsp_valid[g] && rsp_ready[g]) begin
                    pend   <= 1'b0;
                    mcount <= mcount + 16'd1;
                end
            end
        end

        always @(negedge clk) begin
            if (!clr) begin
                chk1("rst rsp_valid", rsp_valid[g], 1'b0);
                chk1("rst alu_rst", alu_rst, 1'b1);
                chk1("rst alu_noop", alu_noop, 1'b1);
                chk1("rst alu_ld", alu_ld, 1'b0);
                chk1("rst req_ready", req_ready[g], 1'b0);
                chk1("rst busy", busy[g], 1'b1);
                chk("rst op_count", 32'(op_count[g]), 32'd0);
                chk("rst alu_cmd", 32'(alu_cmd), 32'd0);
                chk("rst rsp_data", rsp_data[g], 32'd0);
            end else begin
                chk1("req_ready", req_ready[g], exp_ready);
                chk1("busy", busy[g], !exp_ready);
                chk("op_count", 32'(op_count[g]), 32'(mcount));
                chk1("alu_rst", alu_rst, m_init);
                if (!pend) begin
                    chk1("idle rsp_valid", rsp_valid[g], 1'b0);
                    chk1("idle alu_ld", alu_ld, 1'b0);
                    chk1("idle alu_noop", alu_noop, 1'b1);
                end else begin
                    if (rsp_valid[g]) begin
                        chk("rsp_data", rsp_data[g], exp_data);
                        chk1("rsp_ovf", rsp_ovf[g], exp_ovf);
                        chk1("rsp_err", rsp_err[g], exp_err);
                    end else if (!exp_err) begin
                        chk1("busy alu_noop", alu_noop, 1'b0);
                    end
                    if (exp_err)
                        chk1("err alu_ld", alu_ld, 1'b0);
                    if (alu_ld) begin
                        chk("issue alu_cmd", 32'(alu_cmd), 32'(exp_cmd));
                        chk("issue alu_a", 32'(alu_a), 32'(exp_a));
                        chk("issue alu_b", 32'(alu_b), 32'(exp_b));
                    end
                end
            end
        end
    end

    // One request on lane i with hand-computed latency and response.
    task automatic run_op(input int i, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int lat, input logic rdy, input int hold,
                          input logic [31:0] d, input logic o, input logic e);
        int t;
        int k;
        @(negedge clk);
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
        req_valid[i] = 1'b1;
        rsp_ready[i] = rdy;
        t = 0;
        while (!req_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1("req accept", req_ready[i], 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        k = 1;
        while (!rsp_valid[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("lit rsp_data", rsp_data[i], d);
        chk1("lit rsp_ovf", rsp_ovf[i], o);
        chk1("lit rsp_err", rsp_err[i], e);
        if (!rdy) begin
            repeat (hold) begin
                @(negedge clk);
                chk("held rsp_data", rsp_data[i], d);
                chk1("held rsp_valid", rsp_valid[i], 1'b1);
                chk1("held req_ready", req_ready[i], 1'b0);
            end
            rsp_ready[i] = 1'b1;
        end
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk1("post rsp_valid", rsp_valid[i], 1'b0);
        chk1("post req_ready", req_ready[i], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_op[i]    = 5'd0;
            req_a[i]     = 16'd0;
            req_b[i]     = 16'd0;
            rsp_ready[i] = 1'b0;
        end
        #1 clr = 1'b0;
        repeat (2) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk1("init alu_rst", lane[0].alu_rst, 1'b1);
        chk1("init req_ready", req_ready[0], 1'b0);
        chk1("init busy", busy[0], 1'b1);
        @(negedge clk);
        chk1("idle alu_rst", lane[0].alu_rst, 1'b0);
        chk1("idle req_ready", req_ready[0], 1'b1);
        chk("idle op_count", 32'(op_count[0]), 32'd0);

        // LAT=1 lane
        run_op(0, 5'd20, 16'd1,     16'd2,     1, 1'b0, 2, 32'h0000_0000, 1'b0, 1'b1);
        chk("op_count after illegal", 32'(op_count[0]), 32'd1);
        run_op(0, 5'd0,  16'hFFFF,  16'h0001,  3, 1'b1, 0, 32'h0001_0000, 1'b1, 1'b0);
        run_op(0, 5'd3,  16'd100,   16'd0,     1, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op(0, 5'd11, 16'h00F0,  16'h0F00,  3, 1'b0, 0, 32'h0000_F00F, 1'b0, 1'b0);
        run_op(0, 5'd12, 16'd5,     16'd5,     1, 1'b1, 0, 32'h0000_0000, 1'b0, 1'b1);
        run_op(0, 5'd3,  16'd100,   16'd7,     3, 1'b0, 0, 32'd14,        1'b0, 1'b0);
        run_op(0, 5'd1,  16'd10,    16'd3,     3, 1'b1, 0, 32'd7,         1'b0, 1'b0);
        chk("op_count lane0", 32'(op_count[0]), 32'd7);

        // LAT=4 lane
        run_op(1, 5'd2,  16'd300,   16'd300,   6, 1'b0, 5, 32'd90000,     1'b0, 1'b0);
        run_op(1, 5'd8,  16'hAAAA,  16'h0FF0,  6, 1'b1, 0, 32'h0000_A55A, 1'b0, 1'b0);
        chk("op_count lane1", 32'(op_count[1]), 32'd2);

        // Reset in the middle of WAIT abandons the operation
        @(negedge clk);
        req_op[1] = 5'd0; req_a[1] = 16'd1; req_b[1] = 16'd2; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk1("async rsp_valid", rsp_valid[1], 1'b0);
        chk1("async alu_rst", lane[1].alu_rst, 1'b1);
        chk1("async busy", busy[1], 1'b1);
        chk1("async req_ready", req_ready[1], 1'b0);
        chk("async op_count", 32'(op_count[1]), 32'd0);
        repeat (4) @(negedge clk);
        chk1("held rst rsp_valid", rsp_valid[1], 1'b0);
        #2 clr = 1'b1;
        @(negedge clk);
        chk1("recover req_ready", req_ready[1], 1'b1);
        chk1("recover rsp_valid", rsp_valid[1], 1'b0);
        chk("recover op_count", 32'(op_count[1]), 32'd0);
        run_op(1, 5'd0,  16'd2,     16'd3,     6, 1'b0, 0, 32'd5,         1'b0, 1'b0);
        chk("op_count after recover", 32'(op_count[1]), 32'd1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
